// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// A byte without req_last locks the transmitter to its sender until the message ends
// or the owner stays idle for LOCK_TIMEOUT ready cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_load,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked
);

    localparam int unsigned     IdW      = $clog2(NUM_REQ);
    localparam int unsigned     CntW     = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntLimit = CntW'(LOCK_TIMEOUT);
    localparam logic [IdW-1:0]  PtrReset = IdW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            last_q, last_d;
    logic            locked_q, locked_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic [IdW-1:0]     cand;
    logic [IdW-1:0]     winner;
    logic               found;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               fire;
    logic               pick;

    // State register; reset discards any accepted but not yet loaded byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= PtrReset;
            grant_q  <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    // Winner search: first eligible requester after the RR pointer, wrapping.
    always_comb begin
        eligible = req_valid;
        if (locked_q) begin
            eligible          = '0;
            eligible[grant_q] = req_valid[grant_q];
        end
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdW'(i) == winner) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
        // A firing timeout takes the whole cycle; arbitration resumes next cycle.
        fire = (LOCK_TIMEOUT != 0) && (state_q == StIdle) && locked_q && (cnt_q == CntLimit);
        pick = (state_q == StIdle) && tx_ready && found && !fire;
    end

    // Next-state logic: FSM sequencing, lock tracking and the idle timeout counter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        last_d   = last_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick) begin
                    state_d = StLoad;
                    ptr_d   = winner;
                    grant_d = winner;
                    data_d  = sel_data;
                    last_d  = sel_last;
                end
            end
            StLoad: begin
                state_d  = StHold;
                locked_d = ~last_q;
            end
            // Holdoff covers the UART's one-cycle lag in dropping tx_ready.
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fire) begin
            locked_d = 1'b0;
        end
        if (pick || !locked_q || fire) begin
            cnt_d = '0;
        end else if ((state_q == StIdle) && tx_ready && !req_valid[grant_q] &&
                     (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs: accept pulse is combinational in IDLE, load strobe follows the state.
    always_comb begin
        req_ready = '0;
        if (pick) begin
            req_ready[winner] = 1'b1;
        end
        tx_load = (state_q == StLoad);
    end

    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner-case sequences and a randomized
// run checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int LT = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_load;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b1;
    logic [1:0]     grant_id;
    logic           locked;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT outputs captured mid-cycle
    logic [N-1:0] s_ready;
    logic         s_load;
    logic [7:0]   s_data;
    logic [1:0]   s_grant;
    logic         s_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer occupies the transmitter for a cooldown of two cycles after
    // the accept (load, then holdoff); lock ownership and idle counting follow the rules directly.
    bit       m_valid = 0;
    int       m_cool;
    bit       m_load, m_last, m_locked;
    bit [7:0] m_data;
    int       m_grant, m_ptr, m_cnt;
    bit       m_acc, m_fire;
    int       m_win;

    task automatic model_eval();
        int i;
        m_fire = (LT != 0) && (m_cool == 0) && m_locked && (m_cnt == LT);
        m_acc  = 0;
        m_win  = 0;
        if (m_cool == 0 && tx_ready && !m_fire) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_ptr + k) % N;
                if (!m_acc && req_valid[i] && (!m_locked || i == m_grant)) begin
                    m_acc = 1;
                    m_win = i;
                end
            end
        end
    endtask

    task automatic model_update();
        bit nl;
        if (rst) begin
            m_valid = 1; m_cool = 0; m_load = 0; m_data = 0; m_last = 0;
            m_grant = 0; m_ptr = N - 1; m_locked = 0; m_cnt = 0;
        end else begin
            nl = m_locked;
            if (m_load) nl = !m_last;
            if (m_fire) nl = 0;
            if (m_acc || !m_locked || m_fire) m_cnt = 0;
            else if (m_cool == 0 && tx_ready && !req_valid[m_grant] && m_cnt < LT) m_cnt++;
            m_locked = nl;
            m_load   = m_acc;
            if (m_cool > 0) m_cool--;
            if (m_acc) begin
                m_data  = req_data[8*m_win +: 8];
                m_last  = req_last[m_win];
                m_grant = m_win;
                m_ptr   = m_win;
                m_cool  = 2;
            end
        end
    endtask

    // One clock: sample at the falling edge, compare with the model, advance at the rising edge.
    task automatic tick();
        @(negedge clk);
        s_ready  = req_ready;
        s_load   = tx_load;
        s_data   = tx_data;
        s_grant  = grant_id;
        s_locked = locked;
        model_eval();
        if (m_valid) begin
            check("model req_ready", 32'(s_ready), m_acc ? (32'(1) << m_win) : 32'(0));
            check("model tx_load", 32'(s_load), 32'(m_load));
            check("model tx_data", 32'(s_data), 32'(m_data));
            check("model grant_id", 32'(s_grant), 32'(m_grant));
            check("model locked", 32'(s_locked), 32'(m_locked));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        bit [N-1:0]   valid;
        bit [8*N-1:0] data;
        bit [N-1:0]   last;
        bit           txr;
        bit           chk;
        bit [N-1:0]   e_ready;
        bit           e_load;
        bit [7:0]     e_data;
        bit [1:0]     e_grant;
        bit           e_locked;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit [N-1:0] v, bit [8*N-1:0] d, bit [N-1:0] l, bit t,
                                bit c, bit [N-1:0] er, bit el, bit [7:0] ed, bit [1:0] eg,
                                bit elk);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.txr = t; x.chk = c;
        x.e_ready = er; x.e_load = el; x.e_data = ed; x.e_grant = eg; x.e_locked = elk;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [3];
        logic [7:0] got [4];
        logic       lk  [4];
        bit [N-1:0] active;
        int         idx, nload, j_grant, bad, found;

        // Single byte, then reset landing in the LOAD cycle, then a clean resend.
        tbl.push_back(mk(1, 3'b000, 24'h0,      3'b000, 1, 0, 3'b000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 3'b001, 24'h000041, 3'b001, 1, 1, 3'b001, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 1, 8'h41, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 0, 8'h41, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 0, 8'h41, 0, 0));
        tbl.push_back(mk(0, 3'b010, 24'h005500, 3'b000, 1, 1, 3'b010, 0, 8'h41, 0, 0));
        tbl.push_back(mk(1, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 1, 8'h55, 1, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 3'b001, 24'h000041, 3'b001, 1, 1, 3'b001, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 1, 8'h41, 0, 0));
        tbl.push_back(mk(0, 3'b000, 24'h0,      3'b000, 1, 1, 3'b000, 0, 8'h41, 0, 0));

        foreach (tbl[v]) begin
            rst = tbl[v].rst; req_valid = tbl[v].valid; req_data = tbl[v].data;
            req_last = tbl[v].last; tx_ready = tbl[v].txr;
            tick();
            if (tbl[v].chk) begin
                check($sformatf("vec%0d ready", v), 32'(s_ready), 32'(tbl[v].e_ready));
                check($sformatf("vec%0d load", v), 32'(s_load), 32'(tbl[v].e_load));
                check($sformatf("vec%0d data", v), 32'(s_data), 32'(tbl[v].e_data));
                check($sformatf("vec%0d grant", v), 32'(s_grant), 32'(tbl[v].e_grant));
                check($sformatf("vec%0d locked", v), 32'(s_locked), 32'(tbl[v].e_locked));
            end
        end
        rst = 1'b0;

        // Round-robin with a slow UART: A0,B0,A0,B0.
        do_reset();
        req_valid = 3'b011; req_data = {8'h00, 8'hB0, 8'hA0}; req_last = 3'b011; tx_ready = 1;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int w = 0; w < 40 && found == 0; w++) begin
                tick();
                if (s_load) found = 1;
            end
            check($sformatf("rr load %0d seen", k), found, 1);
            check($sformatf("rr data %0d", k), 32'(s_data), (k % 2 == 0) ? 32'hA0 : 32'hB0);
            check($sformatf("rr grant %0d", k), 32'(s_grant), 32'(k % 2));
            tx_ready = 0;
            repeat (9) tick();
            tx_ready = 1;
        end

        // Locked message from req1 must not interleave with req0.
        do_reset();
        seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12;
        idx = 0; nload = 0;
        req_valid = 3'b010; req_data = {8'h00, 8'h10, 8'h99}; req_last = 3'b000; tx_ready = 1;
        for (int c = 0; c < 60 && nload < 4; c++) begin
            tick();
            if (s_load) begin
                got[nload] = s_data;
                lk[nload]  = s_locked;
                nload++;
            end
            if (s_ready[1]) idx++;
            req_valid = {1'b0, idx < 3, 1'b1};
            if (idx < 3) req_data[15:8] = seq[idx];
            req_last = {1'b0, idx == 2, 1'b1};
        end
        check("lock load count", nload, 4);
        if (nload == 4) begin
            check("lock byte0", 32'(got[0]), 32'h10);
            check("lock byte1", 32'(got[1]), 32'h11);
            check("lock byte2", 32'(got[2]), 32'h12);
            check("lock byte3", 32'(got[3]), 32'h99);
            check("lock held at byte1", 32'(lk[1]), 1);
            check("lock held at byte2", 32'(lk[2]), 1);
            check("lock free at byte3", 32'(lk[3]), 0);
        end

        // Lock timeout: owner goes idle after an unterminated byte.
        do_reset();
        req_valid = 3'b010; req_data = {8'h00, 8'h20, 8'h30}; req_last = 3'b000; tx_ready = 1;
        tick();
        check("to accept req1", 32'(s_ready), 32'b010);
        req_valid = 3'b001; req_last = 3'b001;
        j_grant = -1;
        for (int j = 1; j <= 20 && j_grant < 0; j++) begin
            tick();
            if (j == 2) check("to locked in hold", 32'(s_locked), 1);
            if (j == 11) check("to locked at fire", 32'(s_locked), 1);
            if (s_ready[0]) begin
                j_grant = j;
                check("to unlocked at grant", 32'(s_locked), 0);
            end
        end
        check("to grant cycle", j_grant, 12);

        // Backpressure: nothing moves while tx_ready is low.
        do_reset();
        req_valid = 3'b001; req_data = {8'h00, 8'h00, 8'h5A}; req_last = 3'b001; tx_ready = 0;
        bad = 0;
        repeat (50) begin
            tick();
            if (s_ready != 0 || s_load) bad++;
        end
        check("bp quiet cycles", bad, 0);
        tx_ready = 1;
        tick();
        check("bp accept on rise", 32'(s_ready), 32'b001);
        tick();
        check("bp load", 32'(s_load), 1);
        check("bp data", 32'(s_data), 32'h5A);

        // Randomized bursty traffic with occasional resets.
        do_reset();
        active = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) active[i] = ~active[i];
                req_valid[i]      = active[i] && ($urandom_range(3) != 0);
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]       = ($urandom_range(2) == 0);
            end
            tx_ready = ($urandom_range(9) < 7);
            rst      = ($urandom_range(999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
